fib_table_gen: RTL

Parametrised Fibonacci table that builds its contents after reset and then serves registered slice reads.
- After reset, computes F(0)..F(DEPTH-1) into internal storage with one WIDTH-bit adder, one entry per cycle.
- Each lookup returns one OUT_W-bit slice of a table entry, together with per-entry overflow and address-error flags.
- Sits in the obfuscation datapath as the Fibonacci-base source for encoding logic.

---
 rtl/fib_table_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fib_table_gen.sv
// Fibonacci table: builds F(0)..F(DEPTH-1) after reset, then serves one registered OUT_W-bit slice read per cycle.
// Define FIB_SATURATE_EN to store overflowed entries as all-ones instead of the wrapped value.
module fib_table_gen #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128,
  parameter int AW    = 10,
  parameter int OUT_W = 16,
  parameter int SW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  input  logic [SW-1:0]    rd_slice,
  output logic             rd_valid,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_ovf,
  output logic             rd_err
);
  localparam int NS = WIDTH / OUT_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, SERVE} state_t;
  state_t r_state, w_state_next;

  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_ovf_a, r_ovf_b;
  logic [WIDTH:0]   w_sum;
  logic             w_last;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_ovf_flags;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_last = (r_idx == IW'(DEPTH - 1));

  always_comb begin
    w_state_next = r_state;
    if (r_state == INIT && w_last) w_state_next = SERVE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= INIT;
    else      r_state <= w_state_next;
  end

  // Overflow flags track a (the value being written) and b separately: the carry
  // that produces F(k+2) must not mark F(k) or F(k+1), which still fit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= WIDTH'(1);
      r_ovf_a     <= 1'b0;
      r_ovf_b     <= 1'b0;
      r_ovf_flags <= '0;
    end else if (r_state == INIT) begin
      r_ovf_flags[r_idx] <= r_ovf_a;
      r_idx              <= r_idx + 1'b1;
      r_a                <= r_b;
      r_b                <= w_sum[WIDTH-1:0];
      r_ovf_a            <= r_ovf_b;
      r_ovf_b            <= r_ovf_b | w_sum[WIDTH];
    end
  end

`ifdef FIB_SATURATE_EN
  assign w_wr_data = r_ovf_a ? {WIDTH{1'b1}} : r_a;
`else
  assign w_wr_data = r_a;
`endif

  always_ff @(posedge clk) begin
    if (rst && r_state == INIT) r_mem[r_idx] <= w_wr_data;
  end

  logic             w_addr_ok, w_slice_ok;
  logic [IW-1:0]    w_ridx;
  logic [WIDTH-1:0] w_entry;
  logic [OUT_W-1:0] w_slices [NS];
  logic [OUT_W-1:0] w_sel;

  assign w_addr_ok  = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
  assign w_slice_ok = ({1'b0, rd_slice} < (SW + 1)'(NS));
  assign w_ridx     = rd_addr[IW-1:0];
  assign w_entry    = r_mem[w_ridx];

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
      assign w_slices[gi] = w_entry[gi*OUT_W +: OUT_W];
    end
  endgenerate

  always_comb begin
    w_sel = '0;
    for (int s = 0; s < NS; s++) begin
      if (rd_slice == SW'(s)) w_sel = w_slices[s];
    end
  end

  logic             r_rd_valid, r_rd_ovf, r_rd_err;
  logic [OUT_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_ovf   <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == SERVE && rd_req) begin
        r_rd_valid <= 1'b1;
        if (w_addr_ok && w_slice_ok) begin
          r_rd_data <= w_sel;
          r_rd_ovf  <= r_ovf_flags[w_ridx];
          r_rd_err  <= 1'b0;
        end else begin
          r_rd_data <= '0;
          r_rd_ovf  <= 1'b0;
          r_rd_err  <= 1'b1;
        end
      end
    end
  end

  assign ready    = (r_state == SERVE);
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_ovf   = r_rd_ovf;
  assign rd_err   = r_rd_err;
endmodule
